// File: rtl/tmds_channel_encoder_if.sv
// Pixel-side bundle for one TMDS channel encoder: pixel byte, control bits,
// video enable in; encoded symbol and running disparity out.
interface tmds_channel_encoder_if;
    logic [7:0]        data_in;
    logic [1:0]        control_in;
    logic              ve_in;
    logic [9:0]        tmds_out;
    logic signed [4:0] tally_out;

    // Pixel pipeline side
    modport master (
        output data_in,
        output control_in,
        output ve_in,
        input  tmds_out,
        input  tally_out
    );

    // Encoder side
    modport slave (
        input  data_in,
        input  control_in,
        input  ve_in,
        output tmds_out,
        output tally_out
    );
endinterface

// File: rtl/tmds_channel_encoder.sv
// TMDS channel encoder: transition-minimising stage (tm_choice) followed by
// a DC-balance stage with a running-disparity tally and control-token
// insertion during blanking.
// Optional macro TMDS_PIPE_EN: registers qm/ve/control after tm_choice,
// giving 2-cycle latency with an identical symbol sequence.
module tmds_channel_encoder #(
    parameter logic [9:0] CTRL_TOKEN_00 = 10'b1101010100,
    parameter logic [9:0] CTRL_TOKEN_01 = 10'b0010101011,
    parameter logic [9:0] CTRL_TOKEN_10 = 10'b0101010100,
    parameter logic [9:0] CTRL_TOKEN_11 = 10'b1010101011
) (
    input  logic                          clk_in,
    input  logic                          rst_in,
    tmds_channel_encoder_if.slave         bus
);

    // Stage 1: pick XOR or XNOR chaining to minimise transitions.
    // qm[8] = 1 marks XOR encoding, 0 marks XNOR encoding.
    function automatic logic [8:0] tm_choice(input logic [7:0] d);
        logic [3:0] ones;
        logic       use_xnor;
        logic [8:0] q;
        ones = 4'd0;
        for (int i = 0; i < 8; i++) begin
            ones = ones + {3'd0, d[i]};
        end
        use_xnor = (ones > 4'd4) || ((ones == 4'd4) && !d[0]);
        q[0] = d[0];
        for (int i = 1; i < 8; i++) begin
            q[i] = use_xnor ? ~(q[i-1] ^ d[i]) : (q[i-1] ^ d[i]);
        end
        q[8] = ~use_xnor;
        return q;
    endfunction

    function automatic logic [3:0] popcount8(input logic [7:0] v);
        logic [3:0] n;
        n = 4'd0;
        for (int i = 0; i < 8; i++) begin
            n = n + {3'd0, v[i]};
        end
        return n;
    endfunction

    logic [8:0]        w_qm;
    logic [8:0]        w_qm_s;
    logic              w_ve_s;
    logic [1:0]        w_ctrl_s;
    logic [3:0]        w_n1;
    logic [3:0]        w_n0;
    logic signed [4:0] w_diff;
    logic              w_q8;
    logic              w_case_a;
    logic              w_case_b;
    logic [9:0]        w_tmds_d;
    logic signed [4:0] w_tally_d;

    logic [9:0]        r_tmds;
    logic signed [4:0] r_tally;

    assign w_qm = tm_choice(bus.data_in);

`ifdef TMDS_PIPE_EN
    logic [8:0] r_qm;
    logic       r_ve;
    logic [1:0] r_ctrl;

    // Pipeline register between the two stages; reset looks like blanking
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_qm   <= 9'd0;
            r_ve   <= 1'b0;
            r_ctrl <= 2'b00;
        end else begin
            r_qm   <= w_qm;
            r_ve   <= bus.ve_in;
            r_ctrl <= bus.control_in;
        end
    end

    assign w_qm_s   = r_qm;
    assign w_ve_s   = r_ve;
    assign w_ctrl_s = r_ctrl;
`else
    assign w_qm_s   = w_qm;
    assign w_ve_s   = bus.ve_in;
    assign w_ctrl_s = bus.control_in;
`endif

    assign w_q8   = w_qm_s[8];
    assign w_n1   = popcount8(w_qm_s[7:0]);
    assign w_n0   = 4'd8 - w_n1;
    // N1 - N0 lies in -8..+8, fits 5-bit signed
    assign w_diff = $signed({1'b0, w_n1}) - $signed({1'b0, w_n0});

    // Decisions use the tally as registered, before this cycle's update
    assign w_case_a = (r_tally == 5'sd0) || (w_n1 == w_n0);
    assign w_case_b = ((r_tally > 5'sd0) && (w_n1 > w_n0)) ||
                      ((r_tally < 5'sd0) && (w_n0 > w_n1));

    // DC-balance stage: select token or (possibly inverted) qm, update tally
    always_comb begin
        w_tmds_d  = r_tmds;
        w_tally_d = r_tally;
        if (!w_ve_s) begin
            case (w_ctrl_s)
                2'b00:   w_tmds_d = CTRL_TOKEN_00;
                2'b01:   w_tmds_d = CTRL_TOKEN_01;
                2'b10:   w_tmds_d = CTRL_TOKEN_10;
                default: w_tmds_d = CTRL_TOKEN_11;
            endcase
            w_tally_d = 5'sd0;
        end else if (w_case_a) begin
            w_tmds_d = {~w_q8, w_q8, (w_q8 ? w_qm_s[7:0] : ~w_qm_s[7:0])};
            w_tally_d = w_q8 ? (r_tally + w_diff) : (r_tally - w_diff);
        end else if (w_case_b) begin
            w_tmds_d  = {1'b1, w_q8, ~w_qm_s[7:0]};
            w_tally_d = r_tally + $signed({3'b000, w_q8, 1'b0}) - w_diff;
        end else begin
            w_tmds_d  = {1'b0, w_q8, w_qm_s[7:0]};
            w_tally_d = r_tally + w_diff - $signed({3'b000, ~w_q8, 1'b0});
        end
    end

    // Output symbol and running disparity registers
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_tmds  <= 10'd0;
            r_tally <= 5'sd0;
        end else begin
            r_tmds  <= w_tmds_d;
            r_tally <= w_tally_d;
        end
    end

    assign bus.tmds_out  = r_tmds;
    assign bus.tally_out = r_tally;

    // Disparity must stay within -8..+8; anything else means the balance logic broke
    a_tally_range : assert property (@(posedge clk_in) disable iff (rst_in)
        (r_tally >= -5'sd8) && (r_tally <= 5'sd8));

endmodule

// File: tb/tb_tmds_channel_encoder.sv
// Self-checking bench for tmds_channel_encoder: a spec-level model checked
// every cycle plus hand-computed literal vectors. Honors TMDS_PIPE_EN.
module tb_tmds_channel_encoder;

`ifdef TMDS_PIPE_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic clk_in = 1'b0;
    logic rst_in = 1'b0;

    tmds_channel_encoder_if bus ();

    tmds_channel_encoder dut (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .bus    (bus)
    );

    always #5 clk_in = ~clk_in;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int lit_id   = 0;

    typedef struct {
        int         due;
        logic [9:0] sym;
        int         tal;
        int         id;
    } pend_t;
    pend_t pq[$];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) begin
            n_pass++;
        end else begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t",
                     name, act, act, exp, exp, $time);
        end
    endtask

    // Transition-minimised word: prefix parities of d, with odd positions
    // flipped when XNOR chaining is chosen.
    function automatic logic [8:0] m_tm(input logic [7:0] d);
        int   ones;
        bit   xn;
        logic [8:0] q;
        logic [7:0] mask;
        ones = $countones(d);
        xn   = (ones > 4) || (ones == 4 && d[0] == 1'b0);
        for (int i = 0; i < 8; i++) begin
            mask = 8'((1 << (i + 1)) - 1);
            q[i] = (^(d & mask)) ^ (xn && (i % 2 == 1));
        end
        q[8] = !xn;
        return q;
    endfunction

    function automatic void m_encode(input logic ve, input logic [1:0] c, input logic [7:0] d,
                                     input int t, output logic [9:0] sym, output int tn);
        logic [9:0] tok [4];
        logic [8:0] qm;
        int n1, n0, q8;
        tok[0] = 10'h354;
        tok[1] = 10'h0AB;
        tok[2] = 10'h154;
        tok[3] = 10'h2AB;
        if (!ve) begin
            sym = tok[c];
            tn  = 0;
        end else begin
            qm = m_tm(d);
            n1 = $countones(qm[7:0]);
            n0 = 8 - n1;
            q8 = int'(qm[8]);
            if (t == 0 || n1 == n0) begin
                if (q8 == 1) begin
                    sym = {2'b01, qm[7:0]};
                    tn  = t + n1 - n0;
                end else begin
                    sym = {2'b10, ~qm[7:0]};
                    tn  = t + n0 - n1;
                end
            end else if ((t > 0 && n1 > n0) || (t < 0 && n0 > n1)) begin
                sym = {1'b1, qm[8], ~qm[7:0]};
                tn  = t + 2 * q8 + n0 - n1;
            end else begin
                sym = {1'b0, qm[8], qm[7:0]};
                tn  = t + n1 - n0 - 2 * (1 - q8);
            end
        end
    endfunction

    // Per-cycle compare against the model; inputs are stable at the negedge
    // and are the ones the next posedge will sample.
    initial begin
        logic [9:0] m_sym;
        int         m_tal;
        logic       s_ve;
        logic [1:0] s_ctrl;
        logic [7:0] s_d;
        int         t_act;
        m_sym = 10'd0;
        m_tal = 0;
        s_ve = 1'b0;
        s_ctrl = 2'b00;
        s_d = 8'd0;
        forever begin
            @(negedge clk_in);
            t_act = int'(bus.tally_out);
            if (rst_in) begin
                check("reset_sym", int'(bus.tmds_out), 0);
                check("reset_tally", t_act, 0);
                m_sym = 10'd0;
                m_tal = 0;
                s_ve = 1'b0;
                s_ctrl = 2'b00;
                s_d = 8'd0;
            end else begin
                check("model_sym", int'(bus.tmds_out), int'(m_sym));
                check("model_tally", t_act, m_tal);
                check("tally_range", int'(t_act >= -8 && t_act <= 8), 1);
`ifdef TMDS_PIPE_EN
                m_encode(s_ve, s_ctrl, s_d, m_tal, m_sym, m_tal);
                s_ve = bus.ve_in;
                s_ctrl = bus.control_in;
                s_d = bus.data_in;
`else
                m_encode(bus.ve_in, bus.control_in, bus.data_in, m_tal, m_sym, m_tal);
`endif
            end
        end
    end

    // Apply one symbol's inputs; optionally queue a literal expectation that
    // becomes visible LAT edges later.
    task automatic drive(input logic ve, input logic [1:0] c, input logic [7:0] d,
                         input bit chk, input logic [9:0] sym, input int tal);
        pend_t pe;
        bus.ve_in = ve;
        bus.control_in = c;
        bus.data_in = d;
        @(posedge clk_in);
        #1;
        cyc++;
        if (chk) begin
            pe.due = cyc + LAT - 1;
            pe.sym = sym;
            pe.tal = tal;
            pe.id  = lit_id;
            lit_id++;
            pq.push_back(pe);
        end
        while (pq.size() > 0 && pq[0].due <= cyc) begin
            pe = pq.pop_front();
            check($sformatf("lit%0d_sym", pe.id), int'(bus.tmds_out), int'(pe.sym));
            check($sformatf("lit%0d_tally", pe.id), int'(bus.tally_out), pe.tal);
        end
    endtask

    initial begin
        bus.ve_in = 1'b0;
        bus.control_in = 2'b00;
        bus.data_in = 8'h00;

        // Asynchronous reset before any clock edge
        #1 rst_in = 1'b1;
        #1;
        check("async_reset_sym", int'(bus.tmds_out), 0);
        check("async_reset_tally", int'(bus.tally_out), 0);
        @(posedge clk_in);
        @(posedge clk_in);
        #1 rst_in = 1'b0;

        // Control tokens
        drive(1'b0, 2'b00, 8'h00, 1'b1, 10'h354, 0);
        drive(1'b0, 2'b01, 8'hA5, 1'b1, 10'h0AB, 0);
        drive(1'b0, 2'b10, 8'h3C, 1'b1, 10'h154, 0);
        drive(1'b0, 2'b11, 8'hFF, 1'b1, 10'h2AB, 0);

        // Repeated 0x00 from tally 0
        drive(1'b1, 2'b00, 8'h00, 1'b1, 10'h100, -8);
        drive(1'b1, 2'b00, 8'h00, 1'b1, 10'h3FF, 2);
        drive(1'b1, 2'b00, 8'h00, 1'b1, 10'h100, -6);

        // Back to blanking mid-stream, then data restarts from tally 0
        drive(1'b0, 2'b11, 8'h00, 1'b1, 10'h2AB, 0);
        drive(1'b1, 2'b00, 8'h00, 1'b1, 10'h100, -8);

        // Single 0xFF after blanking, then more data exercising the other cases
        drive(1'b0, 2'b00, 8'h00, 1'b1, 10'h354, 0);
        drive(1'b1, 2'b00, 8'hFF, 1'b1, 10'h200, -8);
        drive(1'b1, 2'b00, 8'hFF, 1'b1, 10'h0FF, -2);
        drive(1'b1, 2'b00, 8'h55, 1'b1, 10'h133, -2);
        drive(1'b0, 2'b00, 8'h00, 1'b0, 10'h000, 0);
        drive(1'b0, 2'b00, 8'h00, 1'b0, 10'h000, 0);

        // Reset between edges in the middle of a data stream
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 2'b00, 8'($urandom), 1'b0, 10'h000, 0);
        end
        rst_in = 1'b1;
        #1;
        check("midstream_reset_sym", int'(bus.tmds_out), 0);
        check("midstream_reset_tally", int'(bus.tally_out), 0);
        @(posedge clk_in);
        @(posedge clk_in);
        #1 rst_in = 1'b0;

        // First symbol after release computed from tally 0
        drive(1'b1, 2'b00, 8'h00, 1'b1, 10'h100, -8);

        // Random soak, mostly video with occasional blanking
        for (int i = 0; i < 10000; i++) begin
            drive(($urandom_range(0, 7) != 0), 2'($urandom), 8'($urandom), 1'b0, 10'h000, 0);
        end
        drive(1'b0, 2'b00, 8'h00, 1'b0, 10'h000, 0);
        drive(1'b0, 2'b00, 8'h00, 1'b0, 10'h000, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/tmds_channel_encoder.md
Name: tmds_channel_encoder

Overview:
- Per-channel DVI/HDMI TMDS encoder built around the transition-minimizing stage `tm_choice`, which turns `data_in[7:0]` into a 9-bit `qm`.
- Adds the sequential DC-balance stage: a running-disparity (tally) register, conditional inversion, and control-token insertion during blanking.
- Sits between the video timing/pixel pipeline and the serializer; one instance per colour channel.

Parameters:
- CTRL_TOKEN_00, 10'b1101010100, token emitted for control_in=2'b00
- CTRL_TOKEN_01, 10'b0010101011, token emitted for control_in=2'b01
- CTRL_TOKEN_10, 10'b0101010100, token emitted for control_in=2'b10
- CTRL_TOKEN_11, 10'b1010101011, token emitted for control_in=2'b11

Ports:
- clk_in  input  1  pixel clock
- rst_in  input  1  asynchronous, active-high reset
- data_in  input  8  pixel byte for this channel
- control_in  input  2  {C1,C0} control bits, used when ve_in=0
- ve_in  input  1  video-data-enable; 1 = encode data_in, 0 = emit control token
- tmds_out  output  10  encoded symbol, bit 0 transmitted first
- tally_out  output  5  current running disparity, signed two's complement (verification/debug)

Behaviour:
- Reset: clk_in is the only clock; rst_in is asynchronous and active-high. While asserted, tmds_out=10'd0 and tally=5'sd0. Release takes effect on the next clk_in edge.
- Mid-operation reset immediately clears tmds_out and tally; the first symbol after release is computed from tally=0.
- Latency: one cycle. Inputs sampled at edge k appear on tmds_out after edge k. One symbol per cycle, no stall and no handshake.
- qm = tm_choice(data_in), computed combinationally. Do not duplicate its logic.
- N1 = popcount(qm[7:0]) and N0 = 8 - N1, as 4-bit unsigned values. All tally arithmetic is 5-bit signed; the legal tally range is -8..+8, so no wrap is expected. Verification asserts this range.
- Control period (ve_in=0):
  - tmds_out <= CTRL_TOKEN selected by control_in.
  - tally <= 0.
  - data_in is ignored.
- Data period (ve_in=1), case A — tally==0 or N1==N0:
  - tmds_out[9] = ~qm[8], tmds_out[8] = qm[8].
  - tmds_out[7:0] = qm[8] ? qm[7:0] : ~qm[7:0].
  - tally += qm[8] ? (N1-N0) : (N0-N1).
- Data period, case B — (tally>0 and N1>N0) or (tally<0 and N0>N1):
  - tmds_out = {1, qm[8], ~qm[7:0]}.
  - tally += 2*qm[8] + (N0-N1).
- Data period, case C — otherwise:
  - tmds_out = {0, qm[8], qm[7:0]}.
  - tally += (N1-N0) - 2*(~qm[8]).
- Case selection uses the registered tally, i.e. the value before the update.
- ve_in transitions:
  - 0->1: first data symbol starts from tally=0.
  - 1->0: token is emitted the next cycle and tally clears in the same update.
- tally_out always equals the registered tally.

Optional Feature:
- Macro: TMDS_PIPE_EN.
- Defined: a register stage is inserted after tm_choice, holding qm, ve_in and control_in; all are reset to 0 by rst_in. Latency becomes 2 cycles, and the DC-balance stage uses the registered copies. Symbol sequences are otherwise identical, only shifted by one cycle.
- Undefined: single-stage, 1-cycle latency as specified above.

Test Plan:
- Reset behaviour: assert rst_in with no clock edge -> tmds_out=0, tally_out=0 immediately. Release, then ve_in=0, control_in=2'b00 -> tmds_out=10'b1101010100 after 1 cycle.
- Control tokens: ve_in=0, control_in=00/01/10/11 on consecutive cycles -> 0x354, 0x0AB, 0x154, 0x2AB, with tally_out=0 throughout.
- Repeated 0x00 from tally 0: ve_in=1, data_in=0x00 for 3 cycles ->
  - tmds_out = 0x100, 0x3FF, 0x100
  - tally_out = -8, +2, -6
- Single 0xFF from tally 0: ve_in=1, data_in=0xFF after a control period -> tmds_out=0x200, tally_out=-8.
- Mid-stream return to blanking: after the 0x00 sequence (tally=-6), drop ve_in with control_in=2'b11 -> tmds_out=0x2AB, tally_out=0. Next data 0x00 -> 0x100, tally_out=-8.
- Async reset and random soak:
  - Assert rst_in between clock edges mid data stream -> outputs clear without waiting for an edge.
  - Random 10k-symbol stream checked against a reference model; tally stays within -8..+8. Repeat with TMDS_PIPE_EN, expecting identical symbols delayed by 1 cycle.
